golden_nonce_uart_tx: RTL and testbench

//   Transmit side of the miner result path. Golden nonces are produced by the hasher control unit
//   (one-cycle strobe with a 32-bit value). This block buffers them in a small FIFO and serialises

---
 rtl/golden_nonce_uart_tx.sv | 176 +++++++++++++++++
 tb/tb_golden_nonce_uart_tx.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/golden_nonce_uart_tx.sv
// Golden-nonce result path: a small nonce FIFO feeding an 8N1 UART transmitter.
// Each nonce goes out as a 5-byte frame: HEADER_BYTE, then the nonce MSB first.
module golden_nonce_uart_tx #(
    parameter int unsigned BAUD_DIV        = 434,
    parameter int unsigned FIFO_DEPTH_LOG2 = 2,
    parameter logic [7:0]  HEADER_BYTE     = 8'h55
) (
    input  logic                       hash_clk,
    input  logic                       reset,
    input  logic                       nonce_valid,
    input  logic [31:0]                golden_nonce,
    output logic                       uart_tx,
    output logic                       tx_busy,
    output logic [FIFO_DEPTH_LOG2:0]   fifo_count,
    output logic                       overflow
);

    localparam int unsigned             DEPTH      = 1 << FIFO_DEPTH_LOG2;
    localparam logic [15:0]             BAUD_LAST  = 16'(BAUD_DIV - 1);
    localparam logic [FIFO_DEPTH_LOG2:0] FULL_COUNT = (FIFO_DEPTH_LOG2 + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t state, state_next;

    logic [31:0]                mem [DEPTH];
    logic [FIFO_DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic                       fifo_empty, fifo_full, push, pop;

    logic [15:0] baud_cnt, baud_next;
    logic [2:0]  bit_idx, bit_next;
    logic [2:0]  byte_idx, byte_next;
    logic [7:0]  shift, shift_next;
    logic [31:0] hold, hold_next;
    logic        tx_next;
    logic        baud_done;
    logic [7:0]  next_byte;

    assign fifo_empty = (fifo_count == '0);
    assign fifo_full  = (fifo_count == FULL_COUNT);
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push       = nonce_valid && (!fifo_full || pop);
    assign baud_done  = (baud_cnt == '0);
    assign tx_busy    = (state != IDLE) || !fifo_empty;

    // FIFO pointers, occupancy and sticky overflow flag
    always_ff @(posedge hash_clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
            if (nonce_valid && fifo_full && !pop) overflow <= 1'b1;
        end
    end

    // FIFO storage; the nonce is captured at push time
    always_ff @(posedge hash_clk) begin
        if (push) mem[wr_ptr] <= golden_nonce;
    end

    // Payload byte following the one just sent (byte_idx 0 was the header)
    always_comb begin
        case (byte_idx)
            3'd0:    next_byte = hold[31:24];
            3'd1:    next_byte = hold[23:16];
            3'd2:    next_byte = hold[15:8];
            default: next_byte = hold[7:0];
        endcase
    end

    // Transmitter state and datapath registers; uart_tx is registered
    always_ff @(posedge hash_clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            shift    <= '0;
            hold     <= '0;
            uart_tx  <= 1'b1;
        end else begin
            state    <= state_next;
            baud_cnt <= baud_next;
            bit_idx  <= bit_next;
            byte_idx <= byte_next;
            shift    <= shift_next;
            hold     <= hold_next;
            uart_tx  <= tx_next;
        end
    end

    // Next-state logic: each state holds for BAUD_DIV cycles per bit; a new frame
    // is launched directly from the final stop bit when another nonce is waiting
    always_comb begin
        state_next = state;
        baud_next  = baud_cnt;
        bit_next   = bit_idx;
        byte_next  = byte_idx;
        shift_next = shift;
        hold_next  = hold;
        tx_next    = uart_tx;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    hold_next  = mem[rd_ptr];
                    byte_next  = '0;
                    shift_next = HEADER_BYTE;
                    baud_next  = BAUD_LAST;
                    tx_next    = 1'b0;
                    state_next = START;
                end
            end
            START: begin
                if (baud_done) begin
                    state_next = DATA;
                    bit_next   = '0;
                    baud_next  = BAUD_LAST;
                    tx_next    = shift[0];
                end else begin
                    baud_next = baud_cnt - 1'b1;
                end
            end
            DATA: begin
                if (baud_done) begin
                    baud_next = BAUD_LAST;
                    if (bit_idx == 3'd7) begin
                        state_next = STOP;
                        tx_next    = 1'b1;
                    end else begin
                        bit_next   = bit_idx + 3'd1;
                        shift_next = shift >> 1;
                        tx_next    = shift[1];
                    end
                end else begin
                    baud_next = baud_cnt - 1'b1;
                end
            end
            STOP: begin
                if (baud_done) begin
                    if (byte_idx != 3'd4) begin
                        byte_next  = byte_idx + 3'd1;
                        shift_next = next_byte;
                        baud_next  = BAUD_LAST;
                        tx_next    = 1'b0;
                        state_next = START;
                    end else if (!fifo_empty) begin
                        pop        = 1'b1;
                        hold_next  = mem[rd_ptr];
                        byte_next  = '0;
                        shift_next = HEADER_BYTE;
                        baud_next  = BAUD_LAST;
                        tx_next    = 1'b0;
                        state_next = START;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    baud_next = baud_cnt - 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_golden_nonce_uart_tx.sv
// Self-checking bench for golden_nonce_uart_tx: a frame-level reference model
// checked every cycle, a UART line decoder, and hand-computed literal checks.
module tb_golden_nonce_uart_tx;

    localparam int unsigned B     = 4;
    localparam int unsigned L     = 2;
    localparam int unsigned DEPTH = 4;

    logic         hash_clk = 1'b0;
    logic         reset;
    logic         nonce_valid;
    logic [31:0]  golden_nonce;
    logic         uart_tx;
    logic         tx_busy;
    logic [L:0]   fifo_count;
    logic         overflow;

    int passed = 0;
    int total  = 0;
    bit cmp_en = 1'b0;

    golden_nonce_uart_tx #(
        .BAUD_DIV(B),
        .FIFO_DEPTH_LOG2(L),
        .HEADER_BYTE(8'h55)
    ) dut (
        .hash_clk(hash_clk),
        .reset(reset),
        .nonce_valid(nonce_valid),
        .golden_nonce(golden_nonce),
        .uart_tx(uart_tx),
        .tx_busy(tx_busy),
        .fifo_count(fifo_count),
        .overflow(overflow)
    );

    always #5 hash_clk = ~hash_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        else passed++;
    endtask

    // ---------------- reference model (frame = 50 bit periods) ----------------
    logic [31:0] mq[$];
    bit          m_active;
    int          m_t;
    logic [49:0] m_bits;
    bit          m_ovf;
    bit          m_pop;
    logic [31:0] m_head;

    function automatic logic [49:0] frame_bits(input logic [31:0] n);
        logic [49:0] f;
        logic [7:0]  by;
        for (int k = 0; k < 5; k++) begin
            by = (k == 0) ? 8'h55 : n[8*(4-k) +: 8];
            f[10*k] = 1'b0;
            for (int i = 0; i < 8; i++) f[10*k+1+i] = by[i];
            f[10*k+9] = 1'b1;
        end
        return f;
    endfunction

    always @(posedge hash_clk or posedge reset) begin
        if (reset) begin
            mq.delete();
            m_active = 1'b0;
            m_t      = 0;
            m_ovf    = 1'b0;
        end else begin
            m_pop = 1'b0;
            if (m_active) begin
                m_t++;
                if (m_t == 50 * B) m_active = 1'b0;
            end
            if (!m_active && mq.size() > 0) begin
                m_pop  = 1'b1;
                m_head = mq.pop_front();
            end
            if (nonce_valid) begin
                if (mq.size() < DEPTH) mq.push_back(golden_nonce);
                else m_ovf = 1'b1;
            end
            if (m_pop) begin
                m_bits   = frame_bits(m_head);
                m_active = 1'b1;
                m_t      = 0;
            end
        end
    end

    // Every-cycle comparison against the model
    always @(negedge hash_clk) begin
        if (cmp_en && !reset) begin
            chk("model_tx",    {31'b0, uart_tx},    {31'b0, m_active ? m_bits[m_t / B] : 1'b1});
            chk("model_busy",  {31'b0, tx_busy},    {31'b0, m_active || mq.size() != 0});
            chk("model_count", {29'b0, fifo_count}, mq.size());
            chk("model_ovf",   {31'b0, overflow},   {31'b0, m_ovf});
        end
    end

    // ---------------- UART line decoder ----------------
    logic [7:0]  rx_bytes[$];
    logic [31:0] exp_nonces[$];

    task automatic uart_rx(input int n);
        logic [7:0] by;
        int w;
        for (int b = 0; b < n; b++) begin
            w = 0;
            while (uart_tx !== 1'b0 && w < 2000) begin
                @(negedge hash_clk);
                w++;
            end
            if (w >= 2000) begin
                chk("rx_timeout", 32'd1, 32'd0);
                return;
            end
            repeat (B / 2) @(negedge hash_clk);
            chk("rx_start", {31'b0, uart_tx}, 32'd0);
            for (int i = 0; i < 8; i++) begin
                repeat (B) @(negedge hash_clk);
                by[i] = uart_tx;
            end
            repeat (B) @(negedge hash_clk);
            chk("rx_stop", {31'b0, uart_tx}, 32'd1);
            rx_bytes.push_back(by);
        end
    endtask

    task automatic check_frames();
        logic [7:0] e;
        foreach (exp_nonces[j]) begin
            for (int k = 0; k < 5; k++) begin
                e = (k == 0) ? 8'h55 : exp_nonces[j][8*(4-k) +: 8];
                if (rx_bytes.size() == 0) chk("rx_missing", 32'd0, {24'b0, e});
                else chk("rx_byte", {24'b0, rx_bytes.pop_front()}, {24'b0, e});
            end
        end
        chk("rx_extra", rx_bytes.size(), 32'd0);
        rx_bytes.delete();
        exp_nonces.delete();
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_tx"},    {31'b0, uart_tx},    32'd1);
        chk({tag, "_busy"},  {31'b0, tx_busy},    32'd0);
        chk({tag, "_count"}, {29'b0, fifo_count}, 32'd0);
        chk({tag, "_ovf"},   {31'b0, overflow},   32'd0);
    endtask

    task automatic do_reset(input string tag);
        @(posedge hash_clk);
        #1 reset = 1'b1;
        #1 reset_checks(tag);
        @(negedge hash_clk);
        reset = 1'b0;
    endtask

    logic [31:0] n5 [6];
    logic [31:0] n4 [6];

    initial begin
        reset        = 1'b1;
        nonce_valid  = 1'b0;
        golden_nonce = '0;
        #2 reset_checks("rst0");
        repeat (2) @(negedge hash_clk);
        reset  = 1'b0;
        cmp_en = 1'b1;

        // Single frame, latency and length
        fork uart_rx(5); join_none
        @(negedge hash_clk); nonce_valid = 1'b1; golden_nonce = 32'h95A1B2C3;
        @(negedge hash_clk); nonce_valid = 1'b0; golden_nonce = 32'hDEADBEEF;
        chk("t2_count_after_push", {29'b0, fifo_count}, 32'd1);
        chk("t2_tx_before_start",  {31'b0, uart_tx},    32'd1);
        @(negedge hash_clk);
        chk("t2_tx_start",  {31'b0, uart_tx},    32'd0);
        chk("t2_busy",      {31'b0, tx_busy},    32'd1);
        chk("t2_count_pop", {29'b0, fifo_count}, 32'd0);
        repeat (199) @(negedge hash_clk);
        chk("t2_busy_end_minus1", {31'b0, tx_busy}, 32'd1);
        @(negedge hash_clk);
        chk("t2_busy_end", {31'b0, tx_busy}, 32'd0);
        exp_nonces.push_back(32'h95A1B2C3);
        check_frames();

        // Two back-to-back frames
        fork uart_rx(10); join_none
        @(negedge hash_clk); nonce_valid = 1'b1; golden_nonce = 32'h00000001;
        @(negedge hash_clk); golden_nonce = 32'hFFFFFFFE;
        chk("t3_count_e0", {29'b0, fifo_count}, 32'd1);
        @(negedge hash_clk); nonce_valid = 1'b0;
        chk("t3_count_e1", {29'b0, fifo_count}, 32'd1);
        chk("t3_tx_start", {31'b0, uart_tx},    32'd0);
        repeat (399) @(negedge hash_clk);
        chk("t3_busy_end_minus1", {31'b0, tx_busy}, 32'd1);
        @(negedge hash_clk);
        chk("t3_busy_end", {31'b0, tx_busy}, 32'd0);
        exp_nonces.push_back(32'h00000001);
        exp_nonces.push_back(32'hFFFFFFFE);
        check_frames();

        // Push into a full FIFO on the same edge as a pop
        do_reset("rst5");
        n5 = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 32'h55555555, 32'h77777777};
        fork uart_rx(30); join_none
        @(negedge hash_clk); nonce_valid = 1'b1; golden_nonce = n5[0];
        for (int i = 1; i < 5; i++) begin
            @(negedge hash_clk); golden_nonce = n5[i];
        end
        @(negedge hash_clk); nonce_valid = 1'b0;
        chk("t5_count_full", {29'b0, fifo_count}, 32'd4);
        chk("t5_ovf_full",   {31'b0, overflow},   32'd0);
        repeat (196) @(negedge hash_clk);
        chk("t5_count_before", {29'b0, fifo_count}, 32'd4);
        nonce_valid = 1'b1; golden_nonce = n5[5];
        @(negedge hash_clk); nonce_valid = 1'b0;
        chk("t5_count_after", {29'b0, fifo_count}, 32'd4);
        chk("t5_ovf_after",   {31'b0, overflow},   32'd0);
        repeat (1000) @(negedge hash_clk);
        chk("t5_busy_end", {31'b0, tx_busy}, 32'd0);
        for (int i = 0; i < 6; i++) exp_nonces.push_back(n5[i]);
        check_frames();

        // Six pushes while idle: one popped, four queued, one dropped
        n4 = '{32'hA0000001, 32'hB0000002, 32'hC0000003, 32'hD0000004, 32'hE0000005, 32'hF0000006};
        fork uart_rx(25); join_none
        @(negedge hash_clk); nonce_valid = 1'b1; golden_nonce = n4[0];
        for (int i = 1; i < 6; i++) begin
            @(negedge hash_clk); golden_nonce = n4[i];
        end
        @(negedge hash_clk); nonce_valid = 1'b0;
        chk("t4_count", {29'b0, fifo_count}, 32'd4);
        chk("t4_ovf",   {31'b0, overflow},   32'd1);
        repeat (996) @(negedge hash_clk);
        chk("t4_busy_end",  {31'b0, tx_busy},  32'd0);
        chk("t4_ovf_stays", {31'b0, overflow}, 32'd1);
        for (int i = 0; i < 5; i++) exp_nonces.push_back(n4[i]);
        check_frames();

        // Reset during the data bits of byte 2, then a clean frame
        do_reset("rst6a");
        @(negedge hash_clk); nonce_valid = 1'b1; golden_nonce = 32'h01234567;
        @(negedge hash_clk); golden_nonce = 32'h89ABCDEF;
        @(negedge hash_clk); golden_nonce = 32'h13579BDF;
        @(negedge hash_clk); nonce_valid = 1'b0;
        chk("t6_count_queued", {29'b0, fifo_count}, 32'd2);
        repeat (94) @(posedge hash_clk);
        #1 reset = 1'b1;
        #1 reset_checks("t6_midframe");
        @(negedge hash_clk); reset = 1'b0;
        fork uart_rx(5); join_none
        @(negedge hash_clk); nonce_valid = 1'b1; golden_nonce = 32'hC001D00D;
        @(negedge hash_clk); nonce_valid = 1'b0;
        chk("t6_count_new", {29'b0, fifo_count}, 32'd1);
        repeat (201) @(negedge hash_clk);
        chk("t6_busy_end", {31'b0, tx_busy}, 32'd0);
        exp_nonces.push_back(32'hC001D00D);
        check_frames();

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
